fetch_ctrl: RTL

Instruction-fetch sequencer for the zero-latency, word-addressed instruction memory of the out-of-order core. It owns the PC and drives the memory address every cycle. Each fetched {pc, instruction} pair is buffered in a small FIFO and handed to decode over a valid/ready handshake. It also handles redirects from branch resolution and halts when fetch runs past the end of the program image.

---
 rtl/fetch_ctrl_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 82 ++++++++
 rtl/fetch_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared fetch-path types and constants used by the core front end.
//   fetch_entry_t : one buffered fetch result {pc, instr}
//   fetch_state_t : fetch sequencer states
//   INSTR_BYTES   : byte stride between sequential instructions
// ---------------------------------------------------------------------------
package fetch_ctrl_pkg;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO of fetch_entry_t with first-word fall-through output.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   push, pop      : write / read strobes (a push into a full FIFO is only
//                    honoured when a pop happens in the same cycle)
//   flush          : empties the FIFO; overrides push and pop
//   din, dout      : entry in / head entry out (dout valid when !empty)
//   full, empty    : occupancy flags
//   count          : number of entries held (0..DEPTH)
// ---------------------------------------------------------------------------
module fetch_fifo
    import fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             din,
    output fetch_entry_t             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            do_push;
    logic            do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign dout    = mem[rd_ptr_reg];

    // Guard the strobes locally so the FIFO can never overrun or underrun,
    // whatever the caller does.
    assign do_push = push && !flush && (!full || pop);
    assign do_pop  = pop && !flush && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset: stale contents are never visible because
    // dout is only qualified while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencer. Owns the PC, drives a zero-latency
// word-addressed instruction memory, buffers {pc, instr} pairs and hands
// them to decode over a valid/ready handshake. Handles redirects and stops
// fetching once the PC runs past the end of the program image.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   imem_addr / imem_instr     : memory address (= pc) / returned instruction
//   redirect_valid/redirect_pc : one-cycle redirect request and target
//   out_valid/out_ready        : handshake toward decode
//   out_pc / out_instr         : head entry of the fetch buffer
//   fifo_count                 : fetch buffer occupancy
//   halted                     : high while the sequencer is in HALT
// ---------------------------------------------------------------------------
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          MEM_BYTES  = 2208
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic [31:0]                   imem_addr,
    input  logic [31:0]                   imem_instr,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_pc,
    output logic [31:0]                   out_instr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          halted
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    fetch_state_t   state_reg;
    logic [31:0]    pc_reg;
    logic           halted_reg;

    logic           in_image;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;
    logic [31:0]    redirect_target;
    fetch_entry_t   push_entry;
    fetch_entry_t   head_entry;

    assign imem_addr       = pc_reg;
    assign in_image        = (pc_reg < MEM_LIMIT);
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    // A redirect hides the stale head from decode in the same cycle it
    // flushes the buffer, so no wrong-path instruction is ever accepted.
    assign out_valid  = !empty && !redirect_valid;
    assign pop        = out_valid && out_ready;
    assign push       = (state_reg == FETCH) && !redirect_valid && in_image
                        && (!full || pop);

    assign push_entry = '{pc: pc_reg, instr: imem_instr};
    assign out_pc     = head_entry.pc;
    assign out_instr  = head_entry.instr;
    assign halted     = halted_reg;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (push_entry),
        .dout  (head_entry),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            pc_reg     <= RESET_PC;
            halted_reg <= 1'b0;
        end else if (redirect_valid) begin
            pc_reg <= redirect_target;
            if (redirect_target < MEM_LIMIT) begin
                state_reg  <= FETCH;
                halted_reg <= 1'b0;
            end else begin
                state_reg  <= HALT;
                halted_reg <= 1'b1;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg  <= FETCH;
                    halted_reg <= 1'b0;
                end
                FETCH: begin
                    if (!in_image) begin
                        state_reg  <= HALT;
                        halted_reg <= 1'b1;
                    end else if (push) begin
                        pc_reg <= pc_reg + INSTR_BYTES;
                    end
                end
                HALT: begin
                    state_reg  <= HALT;
                    halted_reg <= 1'b1;
                end
                default: begin
                    state_reg  <= IDLE;
                    halted_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule
